decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised successor to the single-cycle decode block: a registered, handshaked instruction-decode stage. It decodes the 16-bit ISA into control signals, reads an integrated register file, and holds the result in an ID/EX pipeline register with valid/ready flow control. It adds load-use stall detection, flush on a taken branch, and a halt state machine. It sits between fetch (upstream) and execute (downstream).

## Interface
- `DATA_W`, 32: register and write-back data width.
- `PC_W`, 16: PC width.
- `REG_CNT`, 8: register count; must be ≤ 8, since instruction register fields are 3 bits. `IDX_W = $clog2(REG_CNT)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid` / `in_ready`  in / out  1  fetch handshake.
- `in_pc`, `in_pc_plus1`  in  PC_W  fetch PC and PC+1.
- `in_inst`  in  16  instruction.
- `flush`  in  1  taken branch/jump resolved in EX; kills younger work.
- `wb_en`  in  1  register-file write enable.
- `wb_reg`  in  IDX_W  write-back register index.
- `wb_data`  in  DATA_W  write-back data.
- `out_valid` / `out_ready`  out / in  1  execute handshake.
- `out_pc`  out  PC_W  PC+1, or the unchanged PC for halt.
- `out_inst`  out  16  instruction copy.
- `out_reg1`, `out_reg2`  out  DATA_W  read data.
- `out_rqrd`, `out_rs`  out  IDX_W  source register indices.
- `out_wr_reg`  out  IDX_W  destination register (`inst[11:9]`).
- `out_wr_en`, `out_branch`, `out_jump`, `out_rqrd_imm`, `out_rs_imm`, `out_mem_wr`, `out_mem_rd`, `out_halt`  out  1  decoded controls.
- `out_alu_ctrl`  out  4  ALU operation.
- `halted`  out  1  high in the HALTED state.

## Operation
- **Decode** (opcode = `inst[15:12]`):
  - halt = `0000`; branch = `0010`; jump = `0100`; store = `0111`; load = `1000`.
  - wr_en = `inst[15]` or opcode `0110`.
  - rqrd_imm = load or store.
  - rs_imm = `inst[15]` & `inst[14]` & !halt.
  - rqrd index = `inst[14]` ? `inst[11:9]` : `inst[5:3]`; rs index = `inst[8:6]`.
- **ALU control:**
  - `1100`→0, `1101`→1, `1110`→2, `1111`→3.
  - `1011`→{0, `inst[2:0]`} if `inst[2:0]` ≠ 0, else 8.
  - `1010`→{1, `inst[2:0]`}.
  - otherwise 15.
- **Register file:** REG_CNT × DATA_W, all entries writable, all reset to 0. Two combinational reads and one write port.
- **Output register:** loads when in_valid & in_ready & !stall & !flush.
  - in_ready = (!out_valid | out_ready) & state==RUN & !stall.
- **Load-use stall:** stall = out_valid & out_mem_rd & out_wr_en & (out_wr_reg == rqrd index or rs index of in_inst) & in_valid.
  - When stall is high and out_ready is high: out_valid drops next cycle (bubble), and in_inst is held by fetch.
- **Flush:** the next cycle has out_valid=0. Any input offered in the flush cycle is consumed (in_ready is unchanged) and discarded.
- **FSM:**
  - RUN → HALTED when a halt instruction is loaded into the output register.
  - HALTED: in_ready=0 and halted=1. The halt entry still drains downstream normally.
  - HALTED → RUN only on flush, which means the halt was on a wrong path. Otherwise HALTED holds until reset.

## Timing
- Latency 1 cycle from accept to out_valid. Throughput 1 instruction per cycle without hazards.
- Outputs hold stable while out_valid & !out_ready.
- Reset (rst=0 at an edge):
  - out_valid=0, all out_* = 0, out_alu_ctrl = 15, halted=0, state=RUN, register file cleared.
  - Reset mid-operation discards the in-flight entry.
- Simultaneous events:
  - flush + stall: flush wins.
  - flush + halt arriving: the halt is discarded and the state stays RUN.
  - flush while in HALTED: next cycle state=RUN, halted=0.
- A write-back is visible to reads from the cycle after the write edge; same-cycle behaviour is set by the macro below.

## Configuration
- `DECODE_RF_BYPASS_EN` defined: a read whose index matches wb_reg while wb_en=1 returns wb_data in the same cycle (write-through).
- Not defined: that read returns the pre-write value. Upstream then guarantees a one-cycle gap.

## Structure
- `decode_pkg`: opcode localparams (OP_HALT, OP_BR, OP_JMP, OP_ST, OP_LD, …), the ALU control encodings, and the FSM state enum {RUN, HALTED}.
- Sub-module `decode_rf`: the register file, parametrised by DATA_W/REG_CNT, containing the bypass logic under the macro.
- Top level: decode logic, hazard logic, FSM, output register.

## Test plan
- **Reset/basic:** after reset, check all outputs are zero (alu_ctrl 15, out_valid=0). Write r2=0x1234 via wb. Send inst `0xC4B0` at PC 5 → next cycle out_valid=1, alu_ctrl=0, rs_imm=1, wr_en=1, out_pc=6.
- **Load-use:** send a load to r3 (`0x8600`), then `0xB0D9` reading r3 → one bubble cycle with out_valid=0 and in_ready=0, then the ALU op issues with alu_ctrl=1.
- **Backpressure:** hold out_ready=0 for 3 cycles → outputs stable and in_ready=0. Release → no loss or duplication across 4 queued instructions.
- **Halt:** send `0x0000` at PC 9 → out_halt=1, out_pc=9, halted=1 next cycle, in_ready stays 0. A flush in the next cycle → halted=0, out_valid=0.
- **Bypass:** wb r1=0xDEAD in the same cycle as a read of r1 → out_reg1=0xDEAD with the macro defined, the old value (0) without.
- **Flush+stall:** assert flush in the cycle a stall is detected → out_valid=0 next cycle and the input is consumed.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU control codes, FSM state and the control bundle
// shared by the decode stage and its register file.
package decode_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_BR   = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b0100;
    localparam logic [3:0] OP_WRR  = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_ALUX = 4'b1010;
    localparam logic [3:0] OP_ALUS = 4'b1011;
    localparam logic [3:0] OP_ALU0 = 4'b1100;
    localparam logic [3:0] OP_ALU1 = 4'b1101;
    localparam logic [3:0] OP_ALU2 = 4'b1110;
    localparam logic [3:0] OP_ALU3 = 4'b1111;

    localparam logic [3:0] ALU_C0  = 4'd0;
    localparam logic [3:0] ALU_C1  = 4'd1;
    localparam logic [3:0] ALU_C2  = 4'd2;
    localparam logic [3:0] ALU_C3  = 4'd3;
    localparam logic [3:0] ALU_S0  = 4'd8;
    localparam logic [3:0] ALU_NOP = 4'd15;

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    typedef struct packed {
        logic       wr_en;
        logic       branch;
        logic       jump;
        logic       rqrd_imm;
        logic       rs_imm;
        logic       mem_wr;
        logic       mem_rd;
        logic       halt;
        logic [3:0] alu;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{alu: ALU_NOP, default: 1'b0};

    // Function field 0 of the short-form ALU group aliases to code 8.
    function automatic logic [3:0] alu_ctrl(input logic [15:0] inst);
        logic [3:0] a;
        case (inst[15:12])
            OP_ALU0: a = ALU_C0;
            OP_ALU1: a = ALU_C1;
            OP_ALU2: a = ALU_C2;
            OP_ALU3: a = ALU_C3;
            OP_ALUS: a = (inst[2:0] != 3'd0) ? {1'b0, inst[2:0]} : ALU_S0;
            OP_ALUX: a = {1'b1, inst[2:0]};
            default: a = ALU_NOP;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/decode_rf.sv
// decode_rf: REG_CNT x DATA_W register file, two async reads, one write.
// DECODE_RF_BYPASS_EN makes a same-cycle write visible to the reads.
module decode_rf
    import decode_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 8,
    localparam int IDX_W   = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [IDX_W-1:0]  ra0_i,
    input  logic [IDX_W-1:0]  ra1_i,
    output logic [DATA_W-1:0] rd0_o,
    output logic [DATA_W-1:0] rd1_o
);

    logic [DATA_W-1:0] mem_q [REG_CNT];

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_CNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

`ifdef DECODE_RF_BYPASS_EN
    assign rd0_o = (we_i && wa_i == ra0_i) ? wd_i : mem_q[ra0_i];
    assign rd1_o = (we_i && wa_i == ra1_i) ? wd_i : mem_q[ra1_i];
`else
    assign rd0_o = mem_q[ra0_i];
    assign rd1_o = mem_q[ra1_i];
`endif

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked decode with regfile, load-use stall,
// flush and halt FSM. Optional write-through via DECODE_RF_BYPASS_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int PC_W    = 16,
    parameter  int REG_CNT = 8,
    localparam int IDX_W   = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_pc_plus1,
    input  logic [15:0]       in_inst,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       out_inst,
    output logic [DATA_W-1:0] out_reg1,
    output logic [DATA_W-1:0] out_reg2,
    output logic [IDX_W-1:0]  out_rqrd,
    output logic [IDX_W-1:0]  out_rs,
    output logic [IDX_W-1:0]  out_wr_reg,
    output logic              out_wr_en,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_rqrd_imm,
    output logic              out_rs_imm,
    output logic              out_mem_wr,
    output logic              out_mem_rd,
    output logic              out_halt,
    output logic [3:0]        out_alu_ctrl,
    output logic              halted
);

    logic [3:0]        op;
    ctrl_t             ctrl_d, ctrl_q;
    logic [IDX_W-1:0]  rq_d, rs_d, wr_d;
    logic [IDX_W-1:0]  rq_q, rs_q, wr_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [15:0]       inst_q;
    logic [DATA_W-1:0] reg1_d, reg2_d, reg1_q, reg2_q;
    logic              valid_d, valid_q;
    state_e            state_q;
    logic              stall, load;

    assign op   = in_inst[15:12];
    assign rq_d = IDX_W'(in_inst[14] ? in_inst[11:9] : in_inst[5:3]);
    assign rs_d = IDX_W'(in_inst[8:6]);
    assign wr_d = IDX_W'(in_inst[11:9]);

    always_comb begin
        ctrl_d          = CTRL_RST;
        ctrl_d.halt     = op == OP_HALT;
        ctrl_d.branch   = op == OP_BR;
        ctrl_d.jump     = op == OP_JMP;
        ctrl_d.mem_wr   = op == OP_ST;
        ctrl_d.mem_rd   = op == OP_LD;
        ctrl_d.wr_en    = in_inst[15] || op == OP_WRR;
        ctrl_d.rqrd_imm = ctrl_d.mem_wr || ctrl_d.mem_rd;
        ctrl_d.rs_imm   = in_inst[15] && in_inst[14] && !ctrl_d.halt;
        ctrl_d.alu      = alu_ctrl(in_inst);
    end

    // Halt keeps its own PC so a restart resumes at the halt itself.
    assign pc_d = ctrl_d.halt ? in_pc : in_pc_plus1;

    decode_rf #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_rf (
        .clk    (clk),
        .rst_ni (rst),
        .we_i   (wb_en),
        .wa_i   (wb_reg),
        .wd_i   (wb_data),
        .ra0_i  (rq_d),
        .ra1_i  (rs_d),
        .rd0_o  (reg1_d),
        .rd1_o  (reg2_d)
    );

    // Flush overrides the load-use stall so the offered input is consumed.
    assign stall = valid_q && ctrl_q.mem_rd && ctrl_q.wr_en && in_valid &&
                   (wr_q == rq_d || wr_q == rs_d) && !flush;

    assign in_ready = (!valid_q || out_ready) && state_q == RUN && !stall;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RST;
            pc_q    <= '0;
            inst_q  <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            rq_q    <= '0;
            rs_q    <= '0;
            wr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                ctrl_q <= ctrl_d;
                pc_q   <= pc_d;
                inst_q <= in_inst;
                reg1_q <= reg1_d;
                reg2_q <= reg2_d;
                rq_q   <= rq_d;
                rs_q   <= rs_d;
                wr_q   <= wr_d;
            end
            case (state_q)
                RUN:    if (load && ctrl_d.halt) state_q <= HALTED;
                HALTED: if (flush) state_q <= RUN;
            endcase
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_inst     = inst_q;
    assign out_reg1     = reg1_q;
    assign out_reg2     = reg2_q;
    assign out_rqrd     = rq_q;
    assign out_rs       = rs_q;
    assign out_wr_reg   = wr_q;
    assign out_wr_en    = ctrl_q.wr_en;
    assign out_branch   = ctrl_q.branch;
    assign out_jump     = ctrl_q.jump;
    assign out_rqrd_imm = ctrl_q.rqrd_imm;
    assign out_rs_imm   = ctrl_q.rs_imm;
    assign out_mem_wr   = ctrl_q.mem_wr;
    assign out_mem_rd   = ctrl_q.mem_rd;
    assign out_halt     = ctrl_q.halt;
    assign out_alu_ctrl = ctrl_q.alu;
    assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus random traffic checked against
// a behavioural model of the decode stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready, flush, wb_en;
    logic [15:0] in_pc, in_pc_plus1, in_inst;
    logic [2:0]  wb_reg;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [15:0] out_pc, out_inst;
    logic [31:0] out_reg1, out_reg2;
    logic [2:0]  out_rqrd, out_rs, out_wr_reg;
    logic        out_wr_en, out_branch, out_jump, out_rqrd_imm;
    logic        out_rs_imm, out_mem_wr, out_mem_rd, out_halt;
    logic [3:0]  out_alu_ctrl;
    logic        halted;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_plus1(in_pc_plus1), .in_inst(in_inst),
        .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_rqrd(out_rqrd), .out_rs(out_rs), .out_wr_reg(out_wr_reg),
        .out_wr_en(out_wr_en), .out_branch(out_branch), .out_jump(out_jump),
        .out_rqrd_imm(out_rqrd_imm), .out_rs_imm(out_rs_imm),
        .out_mem_wr(out_mem_wr), .out_mem_rd(out_mem_rd),
        .out_halt(out_halt), .out_alu_ctrl(out_alu_ctrl), .halted(halted)
    );

    typedef struct packed {
        logic [15:0] pc, inst;
        logic [31:0] r1, r2;
        logic [2:0]  rq, rs, wr;
        logic        wr_en, br, jmp, rq_imm, rs_imm, mwr, mrd, halt;
        logic [3:0]  alu;
    } exp_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_rf [8];
    exp_t        m_o;
    logic        m_valid, m_halted, acc, hs;
    logic [15:0] hs_inst;
    logic [15:0] bp [4];
    logic [15:0] ri;
    int          k, got;

    task automatic check(string tag, logic [63:0] got_v, logic [63:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_rd(logic [2:0] idx);
`ifdef DECODE_RF_BYPASS_EN
        if (wb_en && wb_reg == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    function automatic logic [3:0] ref_alu(logic [15:0] i);
        int op = int'(i[15:12]);
        int f  = int'(i[2:0]);
        if (op >= 12) return 4'(op - 12);
        if (op == 11) return 4'(f != 0 ? f : 8);
        if (op == 10) return 4'(8 + f);
        return 4'd15;
    endfunction

    function automatic exp_t ref_dec(logic [15:0] i, logic [15:0] pc,
                                     logic [15:0] pc1);
        exp_t e;
        int   op = int'(i[15:12]);
        e.halt   = op == 0;
        e.br     = op == 2;
        e.jmp    = op == 4;
        e.mwr    = op == 7;
        e.mrd    = op == 8;
        e.wr_en  = op >= 8 || op == 6;
        e.rq_imm = e.mwr || e.mrd;
        e.rs_imm = op >= 12;
        e.rq     = i[14] ? i[11:9] : i[5:3];
        e.rs     = i[8:6];
        e.wr     = i[11:9];
        e.alu    = ref_alu(i);
        e.pc     = e.halt ? pc : pc1;
        e.inst   = i;
        e.r1     = ref_rd(e.rq);
        e.r2     = ref_rd(e.rs);
        return e;
    endfunction

    task automatic m_reset();
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_o      = '0;
        m_o.alu  = 4'd15;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
    endtask

    task automatic drive(input logic v, input logic [15:0] inst,
                         input logic [15:0] pc, input logic ordy,
                         input logic fl);
        in_valid    = v;
        in_inst     = inst;
        in_pc       = pc;
        in_pc_plus1 = pc + 16'd1;
        out_ready   = ordy;
        flush       = fl;
        wb_en       = 1'b0;
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs.
    task automatic step();
        exp_t d;
        logic stall, rdy;
        #1;
        d     = ref_dec(in_inst, in_pc, in_pc_plus1);
        stall = m_valid && m_o.mrd && m_o.wr_en && in_valid && !flush &&
                (m_o.wr == d.rq || m_o.wr == d.rs);
        rdy   = (!m_valid || out_ready) && !m_halted && !stall;
        check("in_ready", in_ready, rdy);
        hs      = m_valid && out_ready;
        hs_inst = out_inst;
        acc     = in_valid && rdy && !flush;
        @(posedge clk);
        if (!rst) begin
            m_reset();
        end else begin
            if (flush) begin
                m_valid  = 1'b0;
                m_halted = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_o     = d;
                if (d.halt) m_halted = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en) m_rf[wb_reg] = wb_data;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("halted", halted, m_halted);
        check("out_pc", out_pc, m_o.pc);
        check("out_inst", out_inst, m_o.inst);
        check("out_reg1", out_reg1, m_o.r1);
        check("out_reg2", out_reg2, m_o.r2);
        check("out_ctrl",
              {out_rqrd, out_rs, out_wr_reg, out_wr_en, out_branch, out_jump,
               out_rqrd_imm, out_rs_imm, out_mem_wr, out_mem_rd, out_halt,
               out_alu_ctrl},
              {m_o.rq, m_o.rs, m_o.wr, m_o.wr_en, m_o.br, m_o.jmp,
               m_o.rq_imm, m_o.rs_imm, m_o.mwr, m_o.mrd, m_o.halt, m_o.alu});
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        wb_reg  = '0;
        wb_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_alu", out_alu_ctrl, 15);
        check("rst_pc", out_pc, 0);
        check("rst_reg1", out_reg1, 0);
        check("rst_halted", halted, 0);
        rst = 1'b1;

        // basic decode after writing r2
        wb_en = 1'b1; wb_reg = 3'd2; wb_data = 32'h1234;
        step();
        drive(1'b1, 16'hC4B0, 16'd5, 1'b1, 1'b0);
        step();
        check("basic_valid", out_valid, 1);
        check("basic_alu", out_alu_ctrl, 0);
        check("basic_rs_imm", out_rs_imm, 1);
        check("basic_wr_en", out_wr_en, 1);
        check("basic_pc", out_pc, 6);
        check("basic_reg1", out_reg1, 32'h1234);

        // load-use bubble
        drive(1'b1, 16'h8600, 16'd6, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'hB0D9, 16'd7, 1'b1, 1'b0);
        #1;
        check("lu_stall_rdy", in_ready, 0);
        step();
        check("lu_bubble", out_valid, 0);
        step();
        check("lu_issue", out_valid, 1);
        check("lu_alu", out_alu_ctrl, 1);

        // flush coinciding with a stall
        drive(1'b1, 16'h8600, 16'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'hB0D9, 16'd9, 1'b1, 1'b1);
        #1;
        check("fs_consumed", in_ready, 1);
        step();
        check("fs_valid", out_valid, 0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();

        // backpressure with four queued instructions
        bp[0] = 16'hC4B0; bp[1] = 16'hD250; bp[2] = 16'hE0C0; bp[3] = 16'hF1C8;
        k = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            drive(k < 4, bp[k < 4 ? k : 3], 16'(16'h20 + k), c >= 4, 1'b0);
            if (c >= 1 && c <= 3) begin
                #1;
                check("bp_stall_rdy", in_ready, 0);
                check("bp_hold_inst", out_inst, bp[0]);
            end
            step();
            if (hs) begin
                check("bp_order", hs_inst, bp[got]);
                got++;
            end
            if (acc) k++;
        end
        check("bp_count", got, 4);

        // halt entry, hold, and exit on flush
        drive(1'b1, 16'h0000, 16'd9, 1'b1, 1'b0);
        step();
        check("halt_out", out_halt, 1);
        check("halt_pc", out_pc, 9);
        check("halt_state", halted, 1);
        drive(1'b1, 16'hC4B0, 16'd10, 1'b1, 1'b0);
        #1;
        check("halt_rdy", in_ready, 0);
        step();
        check("halt_hold", halted, 1);
        drive(1'b1, 16'hC4B0, 16'd12, 1'b1, 1'b1);
        step();
        check("halt_exit", halted, 0);
        check("halt_flush_valid", out_valid, 0);

        // same-cycle write-back to r1 while reading r1
        drive(1'b1, 16'hC240, 16'd3, 1'b1, 1'b0);
        wb_en = 1'b1; wb_reg = 3'd1; wb_data = 32'hDEAD;
        step();
`ifdef DECODE_RF_BYPASS_EN
        check("byp_reg1", out_reg1, 32'hDEAD);
`else
        check("byp_reg1", out_reg1, 32'h0);
`endif

        // reset mid-operation
        drive(1'b1, 16'hC4B0, 16'd40, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("mid_rst_valid", out_valid, 0);
        rst = 1'b1;
        drive(1'b1, 16'hC4B0, 16'd41, 1'b1, 1'b0);
        step();
        check("mid_rst_rf", out_reg1, 0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            ri = 16'($urandom);
            if (ri[15:12] == 4'h0 && $urandom_range(0, 3) != 0) ri[15:12] = 4'hC;
            if ($urandom_range(0, 3) == 0) ri[15:12] = 4'h8;
            drive($urandom_range(0, 3) != 0, ri, 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            wb_en   = 1'($urandom_range(0, 1));
            wb_reg  = 3'($urandom);
            wb_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
